mor1kx_wb_arbiter_marocchino: RTL and testbench

MOR1KX_WB_ARBITER_MAROCCHINO -- requirements
Module: mor1kx_wb_arbiter_marocchino

---
 rtl/mor1kx_wb_arbiter_marocchino_pkg.sv | 35 +++
 rtl/mor1kx_rr_pick_marocchino.sv | 35 +++
 rtl/mor1kx_wb_arbiter_marocchino.sv | 145 ++++++++++++++
 tb/tb_mor1kx_wb_arbiter_marocchino.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_wb_arbiter_marocchino_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mor1kx_wb_arbiter_marocchino_pkg
//  Description : Shared definitions for the MAROCCHINO write-back arbiter:
//                result-source indices, source count, FSM state encoding
//                and a one-hot to index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mor1kx_wb_arbiter_marocchino_pkg;

    // Number of result sources competing for the write-back port
    localparam int NUM_SRC = 4;

    // Source indices (bit positions in req_i / grant_o)
    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MUL = 2'd1;
    localparam logic [1:0] SRC_DIV = 2'd2;
    localparam logic [1:0] SRC_LSU = 2'd3;

    // Output holding register state: EMPTY <=> wb_valid_o = 0
    typedef enum logic [0:0] {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_t;

    // Encode a one-hot (or zero) 4-bit vector into a 2-bit index
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
        logic [1:0] idx;
        idx[0] = oh[SRC_MUL] | oh[SRC_LSU];
        idx[1] = oh[SRC_DIV] | oh[SRC_LSU];
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mor1kx_rr_pick_marocchino.sv
`default_nettype none
// ============================================================================
//  Module      : mor1kx_rr_pick_marocchino
//  Description : 4-way combinational picker. Searches req starting at
//                pointer+1 and wrapping modulo 4; returns a one-hot grant
//                (all zero when no request is present).
//  Revision    : 1.0 - initial release
// ============================================================================
module mor1kx_rr_pick_marocchino
    import mor1kx_wb_arbiter_marocchino_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         pointer,
    output logic [NUM_SRC-1:0] grant
);

    logic [1:0] idx;
    logic       found;

    // Walk pointer+1 .. pointer+4; the first active request wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = pointer + k[1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mor1kx_wb_arbiter_marocchino.sv
`default_nettype none
// ============================================================================
//  Module      : mor1kx_wb_arbiter_marocchino
//  Description : Write-back arbiter for the MAROCCHINO pipeline. Picks one of
//                four result sources (ALU, MUL, DIV, LSU) and holds its result,
//                destination address and write request in a single output
//                register with valid/ready handshake. Back-to-back loads are
//                possible when the held result is accepted in the same cycle.
//  Config      : OR1K_WB_ARB_ROUND_ROBIN_EN - defined: round-robin with a
//                last-grant pointer; undefined: fixed priority
//                LSU > DIV > MUL > ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module mor1kx_wb_arbiter_marocchino
    import mor1kx_wb_arbiter_marocchino_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
)(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    pipeline_flush_i,
    input  logic                                    wb_ready_i,
    input  logic [NUM_SRC-1:0]                      req_i,
    input  logic [NUM_SRC-1:0]                      rf_wb_i,
    input  logic [NUM_SRC*OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_i,
    input  logic [NUM_SRC*OPTION_OPERAND_WIDTH-1:0] result_i,
    output logic [NUM_SRC-1:0]                      grant_o,
    output logic                                    wb_valid_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]         wb_result_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]         wb_rfd_adr_o,
    output logic                                    wb_rf_wb_o,
    output logic [1:0]                              wb_src_o
);

    localparam int W = OPTION_OPERAND_WIDTH;
    localparam int A = OPTION_RF_ADDR_WIDTH;

    wb_state_t            state;
    wb_state_t            state_next;
    logic                 can_load;
    logic [NUM_SRC-1:0]   pick;
    logic [NUM_SRC-1:0]   grant;
    logic [1:0]           grant_idx;

    // The holding register may take a new result when it is empty or being
    // drained this cycle; a flush blocks any load.
    assign can_load = ~pipeline_flush_i & ((state == WB_EMPTY) | wb_ready_i);

`ifdef OR1K_WB_ARB_ROUND_ROBIN_EN
    logic [1:0] pointer;

    mor1kx_rr_pick_marocchino u_pick (
        .req     (req_i),
        .pointer (pointer),
        .grant   (pick)
    );

    // Last-grant pointer; reset to LSU so the ALU is searched first
    always_ff @(posedge clk) begin
        if (rst) begin
            pointer <= SRC_LSU;
        end else if (|grant) begin
            pointer <= grant_idx;
        end
    end
`else
    // Fixed priority reuses the picker: with the request vector bit-reversed
    // and the pointer pinned at 3, the search order 0,1,2,3 visits
    // LSU, DIV, MUL, ALU.
    logic [NUM_SRC-1:0] req_rev;
    logic [NUM_SRC-1:0] pick_rev;

    mor1kx_rr_pick_marocchino u_pick (
        .req     (req_rev),
        .pointer (SRC_LSU),
        .grant   (pick_rev)
    );

    // Bit-reverse requests into the picker and its grant back out
    always_comb begin
        req_rev = '0;
        pick    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req_rev[i]             = req_i[NUM_SRC-1-i];
            pick[NUM_SRC-1-i]      = pick_rev[i];
        end
    end
`endif

    // Qualify the picker output: no grant under reset, flush or a stalled
    // full register
    always_comb begin
        grant = '0;
        if (can_load && !rst) begin
            grant = pick;
        end
    end

    assign grant_idx = onehot_to_idx(grant);
    assign grant_o   = grant;

    // Next-state logic for the output holding register
    always_comb begin
        state_next = state;
        if (pipeline_flush_i) begin
            state_next = WB_EMPTY;
        end else if (|grant) begin
            state_next = WB_FULL;
        end else if ((state == WB_FULL) && wb_ready_i) begin
            state_next = WB_EMPTY;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    assign wb_valid_o = (state == WB_FULL);

    // Data holding registers: load on grant, kill the write request on flush,
    // otherwise keep the last values (consumers qualify with wb_valid_o)
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_result_o  <= '0;
            wb_rfd_adr_o <= '0;
            wb_rf_wb_o   <= 1'b0;
            wb_src_o     <= '0;
        end else if (|grant) begin
            wb_result_o  <= result_i[grant_idx*W +: W];
            wb_rfd_adr_o <= rfd_adr_i[grant_idx*A +: A];
            wb_rf_wb_o   <= rf_wb_i[grant_idx];
            wb_src_o     <= grant_idx;
        end else if (pipeline_flush_i) begin
            wb_rf_wb_o   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_wb_arbiter_marocchino.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mor1kx_wb_arbiter_marocchino
//  Description : Directed bench for the write-back arbiter. Stimulus pushes
//                expected grants and held results into queues; a monitor
//                pops and compares whenever a grant or a new held result
//                appears. Covers both arbitration modes
//                (OR1K_WB_ARB_ROUND_ROBIN_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mor1kx_wb_arbiter_marocchino;

    localparam int W = 32;
    localparam int A = 5;

    typedef struct packed {
        logic [W-1:0] res;
        logic [A-1:0] adr;
        logic         rfwb;
        logic [1:0]   src;
    } wb_rec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           ready;
    logic [3:0]     req;
    logic [3:0]     rf_wb;
    logic [4*A-1:0] adr;
    logic [4*W-1:0] res;
    logic [3:0]     grant_o;
    logic           wb_valid_o;
    logic [W-1:0]   wb_result_o;
    logic [A-1:0]   wb_rfd_adr_o;
    logic           wb_rf_wb_o;
    logic [1:0]     wb_src_o;

    logic [W-1:0]   src_res  [4];
    logic [A-1:0]   src_adr  [4];
    logic           src_rfwb [4];

    logic [3:0]     grant_q [$];
    wb_rec_t        wb_q    [$];

    int checks = 0;
    int errors = 0;

`ifdef OR1K_WB_ARB_ROUND_ROBIN_EN
    localparam logic [3:0] PRE_RST_GRANT  = 4'b0010;
    localparam logic [3:0] POST_RST_GRANT = 4'b0001;
`else
    localparam logic [3:0] PRE_RST_GRANT  = 4'b1000;
    localparam logic [3:0] POST_RST_GRANT = 4'b1000;
`endif

    always #5 clk = ~clk;

    mor1kx_wb_arbiter_marocchino #(
        .OPTION_OPERAND_WIDTH (W),
        .OPTION_RF_ADDR_WIDTH (A)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pipeline_flush_i (flush),
        .wb_ready_i       (ready),
        .req_i            (req),
        .rf_wb_i          (rf_wb),
        .rfd_adr_i        (adr),
        .result_i         (res),
        .grant_o          (grant_o),
        .wb_valid_o       (wb_valid_o),
        .wb_result_o      (wb_result_o),
        .wb_rfd_adr_o     (wb_rfd_adr_o),
        .wb_rf_wb_o       (wb_rf_wb_o),
        .wb_src_o         (wb_src_o)
    );

    // Pack per-source data onto the DUT buses
    always_comb begin
        res   = '0;
        adr   = '0;
        rf_wb = '0;
        for (int s = 0; s < 4; s++) begin
            res[s*W +: W] = src_res[s];
            adr[s*A +: A] = src_adr[s];
            rf_wb[s]      = src_rfwb[s];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; a nonzero eg queues the expected grant and
    // the result it must load, a zero eg is checked directly as "no grant".
    task automatic step(input logic [3:0] r, input logic rdy, input logic fl,
                        input logic rs, input logic [3:0] eg);
        wb_rec_t rec;
        logic [1:0] idx;
        @(posedge clk);
        #1;
        req   = r;
        ready = rdy;
        flush = fl;
        rst   = rs;
        if (eg != 4'b0) begin
            idx = eg[3] ? 2'd3 : eg[2] ? 2'd2 : eg[1] ? 2'd1 : 2'd0;
            rec.res  = src_res[idx];
            rec.adr  = src_adr[idx];
            rec.rfwb = src_rfwb[idx];
            rec.src  = idx;
            grant_q.push_back(eg);
            wb_q.push_back(rec);
        end
        @(negedge clk);
        if (eg == 4'b0) chk("grant_idle", {60'b0, grant_o}, 64'h0);
    endtask

    // Monitor: compare each grant as it appears, and the held result one
    // cycle after each grant
    initial begin : monitor
        logic    pend;
        wb_rec_t exp_rec;
        logic [3:0] exp_g;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 64'h1, 64'h0);
                end else begin
                    exp_rec = wb_q.pop_front();
                    chk("wb_valid",  {63'b0, wb_valid_o}, 64'h1);
                    chk("wb_result", {32'b0, wb_result_o}, {32'b0, exp_rec.res});
                    chk("wb_adr",    {59'b0, wb_rfd_adr_o}, {59'b0, exp_rec.adr});
                    chk("wb_rf_wb",  {63'b0, wb_rf_wb_o}, {63'b0, exp_rec.rfwb});
                    chk("wb_src",    {62'b0, wb_src_o}, {62'b0, exp_rec.src});
                end
            end
            pend = 1'b0;
            if (grant_o != 4'b0) begin
                if (grant_q.size() == 0) begin
                    chk("grant_unexpected", {60'b0, grant_o}, 64'h0);
                end else begin
                    exp_g = grant_q.pop_front();
                    chk("grant", {60'b0, grant_o}, {60'b0, exp_g});
                end
                pend = !rst;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1; flush = 1'b0; ready = 1'b0; req = 4'b0;
        src_res[0] = 32'h0000_00A0; src_adr[0] = 5'd1;  src_rfwb[0] = 1'b1;
        src_res[1] = 32'h0000_1234; src_adr[1] = 5'd5;  src_rfwb[1] = 1'b1;
        src_res[2] = 32'h0000_00C0; src_adr[2] = 5'd7;  src_rfwb[2] = 1'b0;
        src_res[3] = 32'hDEAD_BEEF; src_adr[3] = 5'd31; src_rfwb[3] = 1'b1;

        // Reset: no grant even with all requests, all outputs zero
        step(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000);
        step(4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000);
        chk("rst_valid",  {63'b0, wb_valid_o}, 64'h0);
        chk("rst_result", {32'b0, wb_result_o}, 64'h0);
        chk("rst_adr",    {59'b0, wb_rfd_adr_o}, 64'h0);
        chk("rst_rf_wb",  {63'b0, wb_rf_wb_o}, 64'h0);
        chk("rst_src",    {62'b0, wb_src_o}, 64'h0);

        // Single request from MUL
        step(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        chk("drain_valid",  {63'b0, wb_valid_o}, 64'h0);
        chk("drain_result", {32'b0, wb_result_o}, 64'h1234);

        // Backpressure: DIV held while ALU waits three cycles
        step(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            step(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000);
            chk("bp_valid",  {63'b0, wb_valid_o}, 64'h1);
            chk("bp_result", {32'b0, wb_result_o}, 64'hC0);
            chk("bp_src",    {62'b0, wb_src_o}, 64'h2);
            chk("bp_adr",    {59'b0, wb_rfd_adr_o}, 64'h7);
        end
        step(4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        // Flush beats ready and request; pointer must stay at MUL
        step(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010);
        step(4'b1000, 1'b1, 1'b1, 1'b0, 4'b0000);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        chk("flush_valid", {63'b0, wb_valid_o}, 64'h0);
        chk("flush_rf_wb", {63'b0, wb_rf_wb_o}, 64'h0);
        step(4'b1011, 1'b1, 1'b0, 1'b0, 4'b1000);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

`ifdef OR1K_WB_ARB_ROUND_ROBIN_EN
        // Round-robin fairness, back-to-back
        step(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001);
        step(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0010);
        step(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0100);
        step(4'b1111, 1'b1, 1'b0, 1'b0, 4'b1000);
        step(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
`else
        // Fixed priority, back-to-back
        step(4'b0111, 1'b1, 1'b0, 1'b0, 4'b0100);
        step(4'b1111, 1'b1, 1'b0, 1'b0, 4'b1000);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
`endif

        // Reset while full with all sources requesting
        step(4'b1111, 1'b0, 1'b0, 1'b0, PRE_RST_GRANT);
        step(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000);
        step(4'b1111, 1'b1, 1'b0, 1'b0, POST_RST_GRANT);
        chk("mid_rst_valid",  {63'b0, wb_valid_o}, 64'h0);
        chk("mid_rst_result", {32'b0, wb_result_o}, 64'h0);
        chk("mid_rst_adr",    {59'b0, wb_rfd_adr_o}, 64'h0);
        chk("mid_rst_rf_wb",  {63'b0, wb_rf_wb_o}, 64'h0);
        chk("mid_rst_src",    {62'b0, wb_src_o}, 64'h0);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

        chk("grant_q_empty", 64'(grant_q.size()), 64'h0);
        chk("wb_q_empty",    64'(wb_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
